// File: rtl/pkg_busca.sv
// pkg_busca: shared addresses, switch causes and fetch states
package pkg_busca;
  localparam int ENDERECO_TROCA_CONTEXTO = 0;
  localparam int ENDERECO_SO = 1000;
  localparam int TAM_SLOT = 1000;
  typedef enum logic [1:0] {
    CAUSA_QUANTUM = 2'b00,
    CAUSA_HALT    = 2'b01,
    CAUSA_FALHA   = 2'b10
  } causa_t;
  typedef enum logic {
    EXEC   = 1'b0,
    PARADO = 1'b1
  } estado_t;
  function automatic int base_programa(input int k);
    return ENDERECO_SO + TAM_SLOT + k * TAM_SLOT;
  endfunction
endpackage

// File: rtl/contador_quantum.sv
// contador_quantum: preemption slice counter with clear, enable and expiry flag
module contador_quantum #(
  parameter int QUANTUM = 64,
  parameter int QUANTUM_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     limpa,
  input  logic                     habilita,
  output logic [QUANTUM_WIDTH-1:0] contagem,
  output logic                     expira
);
  logic [QUANTUM_WIDTH-1:0] contagem_q, contagem_d;
  always_comb begin
    contagem_d = limpa ? '0 : habilita ? contagem_q + QUANTUM_WIDTH'(1) : contagem_q;
  end
  always_ff @(posedge clock) begin
    if (reset) contagem_q <= '0;
    else contagem_q <= contagem_d;
  end
  assign contagem = contagem_q;
  assign expira = contagem_q == QUANTUM_WIDTH'(QUANTUM - 1);
endmodule

// File: rtl/unidade_busca_pc.sv
// unidade_busca_pc: PC/fetch-address stage with quantum preemption and forced context switch
module unidade_busca_pc
  import pkg_busca::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS = 7000,
  parameter int RESET_ADDR = 1000,
  parameter int QUANTUM = 64,
  parameter int QUANTUM_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     para,
  input  logic                     desvio_valido,
  input  logic [ADDR_WIDTH-1:0]    desvio_endereco,
  input  logic                     halt,
  input  logic                     restaura_valido,
  input  logic [ADDR_WIDTH-1:0]    restaura_endereco,
  output logic [ADDR_WIDTH-1:0]    endereco,
  output logic                     instrucao_valida,
  output logic                     modo_usuario,
  output logic                     troca_contexto,
  output logic [1:0]               causa_troca,
  output logic [ADDR_WIDTH-1:0]    pc_salvo,
  output logic [QUANTUM_WIDTH-1:0] contador_quantum
);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, salvo_q, salvo_d, proximo;
  estado_t estado_q, estado_d;
  causa_t causa_q, causa_d;
  logic modo_q, modo_d, valida_q, valida_d, troca_q, troca_d;
  logic emite, falha, forca, parar, avanca, limpa, habilita, expira;
  contador_quantum #(.QUANTUM(QUANTUM), .QUANTUM_WIDTH(QUANTUM_WIDTH)) u_contador (
    .clock(clock),
    .reset(reset),
    .limpa(limpa),
    .habilita(habilita),
    .contagem(contador_quantum),
    .expira(expira)
  );
  always_comb begin
    proximo = desvio_valido ? desvio_endereco : pc_q + ADDR_WIDTH'(1);
    emite = !restaura_valido && !para && estado_q == EXEC;
    falha = emite && proximo >= ADDR_WIDTH'(MEM_WORDS);
    forca = emite && modo_q && (falha || halt || expira);
    parar = emite && !modo_q && (falha || halt);
    avanca = emite && !falha && !halt && !forca;
    limpa = restaura_valido || forca;
    habilita = avanca && modo_q;
    pc_d = restaura_valido ? restaura_endereco
         : forca ? ADDR_WIDTH'(ENDERECO_TROCA_CONTEXTO)
         : avanca ? proximo : pc_q;
    modo_d = restaura_valido ? 1'b1 : forca ? 1'b0 : modo_q;
    estado_d = restaura_valido ? EXEC : parar ? PARADO : estado_q;
    valida_d = avanca && !desvio_valido;
    troca_d = forca;
    causa_d = !forca ? causa_q : falha ? CAUSA_FALHA : halt ? CAUSA_HALT : CAUSA_QUANTUM;
    salvo_d = !forca ? salvo_q : (halt && !falha) ? pc_q : proximo;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= ADDR_WIDTH'(RESET_ADDR);
      estado_q <= EXEC;
      modo_q   <= 1'b0;
      valida_q <= 1'b0;
      troca_q  <= 1'b0;
      causa_q  <= CAUSA_QUANTUM;
      salvo_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      estado_q <= estado_d;
      modo_q   <= modo_d;
      valida_q <= valida_d;
      troca_q  <= troca_d;
      causa_q  <= causa_d;
      salvo_q  <= salvo_d;
    end
  end
  assign endereco = pc_q;
  assign instrucao_valida = valida_q;
  assign modo_usuario = modo_q;
  assign troca_contexto = troca_q;
  assign causa_troca = causa_q;
  assign pc_salvo = salvo_q;
endmodule

// File: tb/tb_unidade_busca_pc.sv
// tb_unidade_busca_pc: directed vector check of the fetch stage with a 4-instruction quantum
module tb_unidade_busca_pc;
  logic clock = 1'b0;
  logic reset, para, desvio_valido, halt, restaura_valido;
  logic [31:0] desvio_endereco, restaura_endereco, endereco, pc_salvo;
  logic instrucao_valida, modo_usuario, troca_contexto;
  logic [1:0] causa_troca;
  logic [15:0] contador_quantum;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic r, p, dv;
    logic [31:0] de;
    logic h, rv;
    logic [31:0] re;
    logic [31:0] e_end;
    logic e_val, e_modo, e_tr;
    logic [1:0] e_cs;
    logic [31:0] e_sv;
    logic [15:0] e_ct;
  } vec_t;
  vec_t tab[$];
  always #5 clock = ~clock;
  unidade_busca_pc #(
    .ADDR_WIDTH(32), .MEM_WORDS(7000), .RESET_ADDR(1000), .QUANTUM(4), .QUANTUM_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .para(para),
    .desvio_valido(desvio_valido),
    .desvio_endereco(desvio_endereco),
    .halt(halt),
    .restaura_valido(restaura_valido),
    .restaura_endereco(restaura_endereco),
    .endereco(endereco),
    .instrucao_valida(instrucao_valida),
    .modo_usuario(modo_usuario),
    .troca_contexto(troca_contexto),
    .causa_troca(causa_troca),
    .pc_salvo(pc_salvo),
    .contador_quantum(contador_quantum)
  );
  task automatic add(input int r, p, dv, de, h, rv, re, e_end, e_val, e_modo, e_tr, e_cs, e_sv, e_ct);
    vec_t v;
    v.r = 1'(r); v.p = 1'(p); v.dv = 1'(dv); v.de = 32'(de); v.h = 1'(h);
    v.rv = 1'(rv); v.re = 32'(re); v.e_end = 32'(e_end); v.e_val = 1'(e_val);
    v.e_modo = 1'(e_modo); v.e_tr = 1'(e_tr); v.e_cs = 2'(e_cs); v.e_sv = 32'(e_sv); v.e_ct = 16'(e_ct);
    tab.push_back(v);
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    reset = v.r; para = v.p; desvio_valido = v.dv; desvio_endereco = v.de;
    halt = v.h; restaura_valido = v.rv; restaura_endereco = v.re;
  endtask
  initial begin
    int n;
    vec_t idle;
    idle = '{default: '0};
    drive(idle);
    add(1,0,0,0,0,0,0,       1000,0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,       1000,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,       1001,1,0,0,0,0,0);
    add(0,0,0,0,0,0,0,       1002,1,0,0,0,0,0);
    add(0,0,0,0,0,1,2000,    2000,0,1,0,0,0,0);
    add(0,0,0,0,0,0,0,       2001,1,1,0,0,0,1);
    add(0,0,0,0,0,0,0,       2002,1,1,0,0,0,2);
    add(0,0,0,0,0,0,0,       2003,1,1,0,0,0,3);
    add(0,0,0,0,0,0,0,       0,0,0,1,0,2004,0);
    add(0,0,0,0,0,0,0,       1,1,0,0,0,2004,0);
    add(0,0,0,0,0,1,2000,    2000,0,1,0,0,2004,0);
    add(0,0,0,0,0,0,0,       2001,1,1,0,0,2004,1);
    add(0,0,0,0,0,0,0,       2002,1,1,0,0,2004,2);
    add(0,0,0,0,0,0,0,       2003,1,1,0,0,2004,3);
    add(0,0,1,2500,0,0,0,    0,0,0,1,0,2500,0);
    add(0,0,0,0,0,1,3009,    3009,0,1,0,0,2500,0);
    add(0,0,0,0,0,0,0,       3010,1,1,0,0,2500,1);
    add(0,0,0,0,1,0,0,       0,0,0,1,1,3010,0);
    add(0,0,1,1005,0,0,0,    1005,0,0,0,1,3010,0);
    add(0,0,0,0,1,0,0,       1005,0,0,0,1,3010,0);
    add(0,0,0,0,0,0,0,       1005,0,0,0,1,3010,0);
    add(0,0,1,1500,0,0,0,    1005,0,0,0,1,3010,0);
    add(0,0,0,0,0,1,4000,    4000,0,1,0,1,3010,0);
    add(0,0,0,0,0,0,0,       4001,1,1,0,1,3010,1);
    add(0,0,1,7000,0,0,0,    0,0,0,1,2,7000,0);
    add(0,0,1,6999,0,0,0,    6999,0,0,0,2,7000,0);
    add(0,0,0,0,0,0,0,       6999,0,0,0,2,7000,0);
    add(0,0,0,0,0,0,0,       6999,0,0,0,2,7000,0);
    add(0,0,0,0,0,1,7005,    7005,0,1,0,2,7000,0);
    add(0,0,0,0,0,0,0,       0,0,0,1,2,7006,0);
    add(0,0,0,0,0,1,2000,    2000,0,1,0,2,7006,0);
    add(0,0,0,0,0,0,0,       2001,1,1,0,2,7006,1);
    add(0,1,0,0,0,0,0,       2001,0,1,0,2,7006,1);
    add(0,1,1,2500,1,0,0,    2001,0,1,0,2,7006,1);
    add(0,1,0,0,0,0,0,       2001,0,1,0,2,7006,1);
    add(0,0,1,2100,0,0,0,    2100,0,1,0,2,7006,2);
    add(0,0,0,0,0,0,0,       2101,1,1,0,2,7006,3);
    add(0,1,0,0,0,1,5000,    5000,0,1,0,2,7006,0);
    add(0,0,0,0,0,0,0,       5001,1,1,0,2,7006,1);
    add(1,0,0,0,0,0,0,       1000,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,       1001,1,0,0,0,0,0);
    foreach (tab[i]) begin
      drive(tab[i]);
      @(posedge clock);
      #1;
      check($sformatf("row%0d_endereco", i), endereco, tab[i].e_end);
      check($sformatf("row%0d_valida", i), 32'(instrucao_valida), 32'(tab[i].e_val));
      check($sformatf("row%0d_modo", i), 32'(modo_usuario), 32'(tab[i].e_modo));
      check($sformatf("row%0d_troca", i), 32'(troca_contexto), 32'(tab[i].e_tr));
      check($sformatf("row%0d_causa", i), 32'(causa_troca), 32'(tab[i].e_cs));
      check($sformatf("row%0d_pc_salvo", i), pc_salvo, tab[i].e_sv);
      check($sformatf("row%0d_contador", i), 32'(contador_quantum), 32'(tab[i].e_ct));
    end
    drive(idle);
    restaura_valido = 1'b1;
    restaura_endereco = 32'd2000;
    @(posedge clock);
    #1;
    restaura_valido = 1'b0;
    n = 0;
    while (!troca_contexto && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("expiry_cycles", 32'(n), 32'd4);
    check("expiry_pc_salvo", pc_salvo, 32'd2004);
    check("expiry_endereco", endereco, 32'd0);
    @(posedge clock);
    #1;
    check("pulse_end", 32'(troca_contexto), 32'd0);
    check("after_pulse_endereco", endereco, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/unidade_busca_pc.md
Name: unidade_busca_pc

Overview:
- Fetch-address stage directly upstream of the instruction RAM. Holds the program counter and drives the RAM word address every cycle.
- Flags which RAM output words are valid, aligned to the RAM's one-cycle synchronous read.
- Enforces the preemption quantum for user programs. On quantum expiry, user halt or bad address, it saves the user PC and redirects fetch to the context-switch routine at word 0.

Parameters:
- ADDR_WIDTH, 32, width of PC, targets and saved PC (word address).
- MEM_WORDS, 7000, instruction RAM depth; addresses >= MEM_WORDS are faults.
- RESET_ADDR, 1000, boot address (OS image).
- QUANTUM, 64, user-mode instructions issued per time slice (>= 2).
- QUANTUM_WIDTH, 16, quantum counter width.

Ports:
- clock  in  1  sole clock; also drives the instruction RAM.
- reset  in  1  synchronous, active-high.
- para  in  1  stall: freeze PC, quantum count and validity.
- desvio_valido  in  1  jump/taken-branch redirect this cycle.
- desvio_endereco  in  ADDR_WIDTH  redirect target.
- halt  in  1  HLT executed.
- restaura_valido  in  1  OS/switch routine loads a user PC (enter user mode).
- restaura_endereco  in  ADDR_WIDTH  PC to resume.
- endereco  out  ADDR_WIDTH  registered PC to instruction RAM.
- instrucao_valida  out  1  RAM output word this cycle is on the correct path.
- modo_usuario  out  1  1 = user program, 0 = supervisor.
- troca_contexto  out  1  one-cycle pulse: forced switch taken.
- causa_troca  out  2  00 quantum, 01 halt, 10 address fault; held until next switch.
- pc_salvo  out  ADDR_WIDTH  resume PC of the preempted program.
- contador_quantum  out  QUANTUM_WIDTH  instructions issued in the current slice.

Behaviour:
- Reset values:
  - endereco = RESET_ADDR; state EXEC; modo_usuario = 0.
  - instrucao_valida, troca_contexto, causa_troca, pc_salvo and contador_quantum all reset to 0.
- States: EXEC (PC advances) and PARADO (halted in supervisor mode, PC frozen).
- Per-edge priority:
  1. reset
  2. restaura_valido
  3. para
  4. fault
  5. halt
  6. quantum expiry, combined with desvio
  7. desvio
  8. increment
- restaura_valido:
  - Updates: endereco = restaura_endereco, modo_usuario = 1, counter = 0, state = EXEC, instrucao_valida = 0.
  - Honoured in any state and even when para = 1.
  - If restaura_endereco >= MEM_WORDS, the fault path applies one cycle later, when the first issue is attempted.
- para = 1: all registers hold; desvio and halt are ignored (upstream holds them); instrucao_valida = 0.
- Issue: a cycle in EXEC with para = 0. Next PC is desvio_endereco if desvio_valido, else endereco + 1.
- Fault: next PC >= MEM_WORDS.
  - User mode: forced switch with cause 10; pc_salvo = offending address.
  - Supervisor mode: go to PARADO.
- halt:
  - User mode: forced switch with cause 01; pc_salvo = endereco.
  - Supervisor mode: enter PARADO; endereco holds.
- Quantum:
  - The counter increments on each user-mode issue.
  - When the counter equals QUANTUM-1 at an issue: forced switch with cause 00; pc_salvo = computed next PC (a redirect target if desvio is present, so redirects are never lost).
- Forced switch, on the same edge:
  - endereco = 0, modo_usuario = 0, counter = 0.
  - troca_contexto = 1 for exactly one cycle; causa_troca and pc_salvo are updated.
- instrucao_valida is a register updated each edge. It is set to 1 only when the edge is a plain sequential issue: EXEC, para = 0, no redirect/switch/halt/restore/fault. The first word after any redirect is therefore squashed.
- The supervisor counter stays 0. Wrap of endereco + 1 beyond ADDR_WIDTH is unreachable because of the fault check.

Decomposition:
- Package pkg_busca:
  - ENDERECO_TROCA_CONTEXTO = 0, ENDERECO_SO = 1000, TAM_SLOT = 1000 (program k base = 2000 + k*1000).
  - causa_troca encodings; FSM state enum.
- Sub-module contador_quantum: counter with clear, enable and expiry output. Everything else stays in the top.

Test Plan:
- Reset: assert reset 2 cycles → endereco = 1000, modo_usuario = 0, outputs 0. Release → endereco 1001, 1002, …; instrucao_valida = 1 from the second edge.
- Preemption (QUANTUM = 4): restaura 2000 → four issues at 2000..2003 → endereco = 0, troca_contexto one-cycle pulse, causa 00, pc_salvo = 2004, modo_usuario = 0.
- Expiry with redirect: 4th issue carries desvio to 2500 → pc_salvo = 2500, endereco = 0, causa 00.
- User halt: at 3010 halt → pc_salvo = 3010, causa 01, endereco = 0. Supervisor halt at 1005 → PARADO, endereco stays 1005; restaura 4000 resumes.
- Fault: user desvio to 7000 → causa 10, pc_salvo = 7000, endereco = 0.
- Stall and squash: para high 3 cycles at 2001 → endereco and counter hold, instrucao_valida = 0. Then desvio to 2100 → the next instrucao_valida = 0, then 1.
